// File: rtl/prpg_pkg.sv
// Shared definitions for the pattern-generator / response-analyzer pair.
// Holds the pattern width, the feedback-tap convention, the analyzer state
// type and the MISR step function. The generator's LFSR and the analyzer's
// MISR must use the same tap meaning, so the step is defined only here.
package prpg_pkg;

  localparam int WIDTH = 8;
  localparam int TAP_W = 7;
  localparam logic [TAP_W-1:0] DEFAULT_TAP = 7'b0001110;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ana_state_t;

  // One MISR step. Bit 0 takes the feedback bit (sig[MSB]) directly.
  // Stage i (1..WIDTH-1) shifts from stage i-1 and XORs in the feedback
  // when tap[TAP_W-i] is set, so tap[6] drives stage 1 and tap[0] drives
  // stage 7. The incoming data word is XORed into every stage.
  function automatic logic [WIDTH-1:0] misr_step(
    input logic [WIDTH-1:0] sig,
    input logic [WIDTH-1:0] data,
    input logic [TAP_W-1:0] tap
  );
    logic [WIDTH-1:0] nxt;
    nxt[0] = sig[WIDTH-1] ^ data[0];
    for (int i = 1; i < WIDTH; i++) begin
      nxt[i] = sig[i-1] ^ (tap[TAP_W-i] & sig[WIDTH-1]) ^ data[i];
    end
    return nxt;
  endfunction

endpackage

// File: rtl/hamming_popcount.sv
// Combinational population count of a WIDTH-bit word. The analyzer feeds it
// the XOR of two successive patterns to obtain their Hamming distance.
// Ports:
//   data   in   WIDTH               word to count
//   count  out  clog2(WIDTH+1)      number of set bits in data
module hamming_popcount #(
  parameter int WIDTH = prpg_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]               data,
  output logic [$clog2(WIDTH+1)-1:0]     count
);

  localparam int CW = $clog2(WIDTH + 1);

  // NOTE: the running sum inside this loop relies on blocking '=' so each
  // iteration sees the previous partial sum; count is defaulted first so no
  // latch can be inferred.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/misr_response_analyzer.sv
// Response analyzer for the PRPG flow. Accepts WIDTH-bit response patterns on
// a valid/ready stream, compacts them into a MISR signature, tracks the
// Hamming distance between successive patterns, and after a programmed count
// compares the signature with a golden value.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_we          latch cfg_tap/seed/len/golden (only in IDLE or DONE)
//   cfg_tap         feedback taps, tap[6] -> stage 1 ... tap[0] -> stage 7
//   cfg_seed        initial signature
//   cfg_len         number of patterns per run
//   cfg_golden      expected final signature
//   start           begin a run (IDLE or DONE only)
//   in_valid/in_data/in_ready   pattern stream
//   busy, done      state indicators (RUN, DONE)
//   pass            signature == golden, only while done
//   signature       current MISR value
//   pat_count       patterns accepted this run
//   hd_last, hd_sum last and accumulated Hamming distance
module misr_response_analyzer #(
  parameter int                WIDTH       = prpg_pkg::WIDTH,
  parameter int                CNT_W       = 9,
  parameter int                HD_W        = 12,
  parameter logic [6:0]        DEFAULT_TAP = prpg_pkg::DEFAULT_TAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [6:0]        cfg_tap,
  input  logic [WIDTH-1:0]  cfg_seed,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [WIDTH-1:0]  cfg_golden,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [WIDTH-1:0]  signature,
  output logic [CNT_W-1:0]  pat_count,
  output logic [3:0]        hd_last,
  output logic [HD_W-1:0]   hd_sum
);

  import prpg_pkg::*;

  localparam int PC_W = $clog2(WIDTH + 1);

  ana_state_t       state, state_next;
  logic [6:0]       tap;
  logic [WIDTH-1:0] seed, golden, prev;
  logic [CNT_W-1:0] len;
  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;
  logic [PC_W-1:0]  hd_now;

  assign xfer    = in_valid && (state == RUN);
  assign cnt_inc = pat_count + CNT_W'(1);

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign pass     = (state == DONE) && (signature == golden);

  hamming_popcount #(.WIDTH(WIDTH)) u_popcount (
    .data  (in_data ^ prev),
    .count (hd_now)
  );

  // NOTE: the state register uses non-blocking '<=' so every flop samples
  // pre-edge values; the decode below is a separate combinational process.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = (len != '0) ? RUN : DONE;
      RUN:        if (xfer && (cnt_inc == len)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Configuration and datapath. start is checked before cfg_we so a start in
  // the same cycle runs with the configuration already latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap       <= DEFAULT_TAP;
      seed      <= '0;
      len       <= '0;
      golden    <= '0;
      prev      <= '0;
      signature <= '0;
      pat_count <= '0;
      hd_last   <= '0;
      hd_sum    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            signature <= seed;
            prev      <= seed;
            pat_count <= '0;
            hd_last   <= '0;
            hd_sum    <= '0;
          end else if (cfg_we) begin
            tap    <= cfg_tap;
            seed   <= cfg_seed;
            len    <= cfg_len;
            golden <= cfg_golden;
          end
        end
        RUN: begin
          if (xfer) begin
            signature <= misr_step(signature, in_data, tap);
            prev      <= in_data;
            pat_count <= cnt_inc;
            hd_last   <= 4'(hd_now);
            hd_sum    <= hd_sum + HD_W'(hd_now);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_misr_response_analyzer.sv
// Directed bench for misr_response_analyzer: a table of complete runs with
// hand-computed per-beat signatures and final results, plus hand-written
// sequences for zero-length runs, start/cfg priority, stream gaps and
// mid-run reset.
module tb_misr_response_analyzer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [6:0]  cfg_tap;
  logic [7:0]  cfg_seed;
  logic [8:0]  cfg_len;
  logic [7:0]  cfg_golden;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready, busy, done, pass;
  logic [7:0]  signature;
  logic [8:0]  pat_count;
  logic [3:0]  hd_last;
  logic [11:0] hd_sum;

  int n_checks = 0;
  int n_fail   = 0;

  misr_response_analyzer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_tap    (cfg_tap),
    .cfg_seed   (cfg_seed),
    .cfg_len    (cfg_len),
    .cfg_golden (cfg_golden),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .pat_count  (pat_count),
    .hd_last    (hd_last),
    .hd_sum     (hd_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  tap;
    logic [7:0]  seed;
    logic [8:0]  len;
    logic [7:0]  golden;
    logic [7:0]  beats [4];
    logic [7:0]  sigs  [4];
    logic        pass;
    logic [3:0]  hd_last;
    logic [11:0] hd_sum;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [6:0] t, input logic [7:0] s,
                           input logic [8:0] l, input logic [7:0] g);
    cfg_we = 1'b1; cfg_tap = t; cfg_seed = s; cfg_len = l; cfg_golden = g;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0; in_data = 8'hAA;
  endtask

  task automatic set_vec(input int idx, input logic [6:0] t, input logic [7:0] s,
                         input logic [8:0] l, input logic [7:0] g,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3,
                         input logic p, input logic [3:0] hl, input logic [11:0] hs);
    vecs[idx].tap = t; vecs[idx].seed = s; vecs[idx].len = l; vecs[idx].golden = g;
    vecs[idx].beats[0] = b0; vecs[idx].beats[1] = b1;
    vecs[idx].beats[2] = b2; vecs[idx].beats[3] = b3;
    vecs[idx].sigs[0] = s0; vecs[idx].sigs[1] = s1;
    vecs[idx].sigs[2] = s2; vecs[idx].sigs[3] = s3;
    vecs[idx].pass = p; vecs[idx].hd_last = hl; vecs[idx].hd_sum = hs;
  endtask

  // Back-to-back run of one table entry, checking the signature after each
  // beat and the final result the cycle after the last beat.
  task automatic run_vec(input int idx);
    configure(vecs[idx].tap, vecs[idx].seed, vecs[idx].len, vecs[idx].golden);
    start_run();
    check($sformatf("v%0d busy", idx), busy, 1);
    check($sformatf("v%0d in_ready", idx), in_ready, 1);
    check($sformatf("v%0d sig_start", idx), signature, vecs[idx].seed);
    for (int i = 0; i < int'(vecs[idx].len); i++) begin
      in_valid = 1'b1; in_data = vecs[idx].beats[i];
      tick();
      check($sformatf("v%0d sig_beat%0d", idx, i), signature, vecs[idx].sigs[i]);
    end
    in_valid = 1'b0; in_data = 8'hAA;
    check($sformatf("v%0d done", idx), done, 1);
    check($sformatf("v%0d in_ready_low", idx), in_ready, 0);
    check($sformatf("v%0d pass", idx), pass, vecs[idx].pass);
    check($sformatf("v%0d pat_count", idx), pat_count, vecs[idx].len);
    check($sformatf("v%0d hd_last", idx), hd_last, vecs[idx].hd_last);
    check($sformatf("v%0d hd_sum", idx), hd_sum, vecs[idx].hd_sum);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " pass"}, pass, 0);
    check({tag, " signature"}, signature, 0);
    check({tag, " pat_count"}, pat_count, 0);
    check({tag, " hd_last"}, hd_last, 0);
    check({tag, " hd_sum"}, hd_sum, 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_tap = '0; cfg_seed = '0; cfg_len = '0;
    cfg_golden = '0; start = 1'b0; in_valid = 1'b0; in_data = '0;

    //       idx tap       seed   len   golden beats                       signatures after each beat  pass hd_last hd_sum
    set_vec(0, 7'h00,    8'h80, 9'd1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 4'd1, 12'd1);
    set_vec(1, 7'h00,    8'h00, 9'd3, 8'h04, 8'h01, 8'h02, 8'h04, 8'h00, 8'h01, 8'h00, 8'h04, 8'h00, 1'b1, 4'd2, 12'd5);
    set_vec(2, 7'b1000000, 8'h80, 9'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 4'd1, 12'd1);
    set_vec(3, 7'h7F,    8'hFF, 9'd2, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h03, 8'h00, 8'h00, 1'b1, 4'd8, 12'd8);

    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    for (int v = 0; v < 4; v++) run_vec(v);

    // Zero-length run: DONE straight from start, in_ready never raised.
    configure(7'h00, 8'h5A, 9'd0, 8'h5A);
    start_run();
    check("len0 done", done, 1);
    check("len0 in_ready", in_ready, 0);
    check("len0 signature", signature, 8'h5A);
    check("len0 pass", pass, 1);
    check("len0 pat_count", pat_count, 0);

    // start and cfg_we together: start uses the old seed, new config dropped.
    cfg_we = 1'b1; cfg_seed = 8'h33; cfg_golden = 8'h33; cfg_len = 9'd0;
    start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check("prio signature", signature, 8'h5A);
    check("prio pass", pass, 1);

    // Stream gaps, IDLE valid pulses, cfg_we/start during RUN.
    rst = 1'b1; tick(); rst = 1'b0;
    configure(7'h00, 8'h00, 9'd3, 8'h04);
    in_valid = 1'b1; in_data = 8'hFF;
    tick(); tick();
    in_valid = 1'b0;
    check("idle_valid pat_count", pat_count, 0);
    check("idle_valid signature", signature, 0);
    start_run();
    beat(8'h01);
    check("gap pat_count1", pat_count, 1);
    cfg_we = 1'b1; cfg_seed = 8'h55; cfg_golden = 8'h77; cfg_len = 9'd1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check("gap signature_hold", signature, 8'h01);
    check("gap busy", busy, 1);
    beat(8'h02);
    tick();
    check("gap pat_count2", pat_count, 2);
    beat(8'h04);
    check("gap done", done, 1);
    check("gap signature", signature, 8'h04);
    check("gap pass", pass, 1);
    check("gap pat_count", pat_count, 3);
    check("gap hd_last", hd_last, 2);
    check("gap hd_sum", hd_sum, 5);

    // Reset mid-run.
    configure(7'h00, 8'h11, 9'd4, 8'h00);
    start_run();
    beat(8'h01);
    beat(8'h02);
    check("midrst pat_count", pat_count, 2);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    // Reset configuration: seed=0, len=0, golden=0.
    start_run();
    check("postrst done", done, 1);
    check("postrst signature", signature, 0);
    check("postrst pass", pass, 1);
    run_vec(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
